// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command dispatcher: unit codes, compare
// sub-function codes, dispatch FSM states and a one-hot decode helper.
package alu_pkg;

  // Unit select carried in CMD_FUN[3:2]; also drives the downstream output mux.
  typedef enum logic [1:0] {
    UNIT_ARITH = 2'b00,
    UNIT_LOGIC = 2'b01,
    UNIT_CMP   = 2'b10,
    UNIT_SHIFT = 2'b11
  } unit_e;

  // Sub-function codes understood by the compare unit.
  typedef enum logic [1:0] {
    CMP_NOP = 2'b00,
    CMP_EQ  = 2'b01,
    CMP_GT  = 2'b10,
    CMP_LT  = 2'b11
  } cmp_fun_e;

  // Dispatch FSM: wait for a command, pulse the unit enable, flag the result.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ISSUE   = 2'b01,
    ST_CAPTURE = 2'b10
  } disp_state_e;

  // Bit n of the result is set for unit code n (arith, logic, cmp, shift).
  function automatic logic [3:0] unit_onehot(input unit_e unit);
    return 4'b0001 << unit;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO. Pointers carry one extra wrap bit so that full
// and empty are distinguished without a separate occupancy counter.
module alu_cmd_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic             CLK_CMP,
  input  logic             RST_CMP,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; a push and a pop in the same cycle both take effect.
  always_ff @(posedge CLK_CMP or negedge RST_CMP) begin
    if (!RST_CMP) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage write.
  // NOTE: the array is deliberately left out of reset; the pointers alone
  // define which entries are valid, and a reset-free array maps to plain RAM.
  always_ff @(posedge CLK_CMP) begin
    if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/alu_cmd_dispatch.sv
// ALU command front end: buffers commands, decodes them into a one-hot unit
// enable plus sub-function, holds operands, and flags the result cycle.
// Optional feature macro: ALU_DISP_STATS_EN builds a 16-bit issue counter
// on ISSUE_CNT; without it ISSUE_CNT is tied to zero.
module alu_cmd_dispatch
  import alu_pkg::*;
#(
  parameter int A_width    = 16,
  parameter int B_width    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               CLK_CMP,
  input  logic               RST_CMP,
  input  logic               CMD_VALID,
  output logic               CMD_READY,
  input  logic [3:0]         CMD_FUN,
  input  logic [A_width-1:0] CMD_A,
  input  logic [B_width-1:0] CMD_B,
  output logic [A_width-1:0] A_OUT,
  output logic [B_width-1:0] B_OUT,
  output logic [1:0]         ALU_FUN_OUT,
  output logic               ARITH_EN,
  output logic               LOGIC_EN,
  output logic               CMP_EN,
  output logic               SHIFT_EN,
  output logic               RES_VALID,
  output logic [1:0]         RES_SEL,
  output logic               BUSY,
  output logic [15:0]        ISSUE_CNT
);

  localparam int FW = 4 + A_width + B_width;

  logic [FW-1:0]      head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic [3:0]         head_fun;
  logic [A_width-1:0] head_a;
  logic [B_width-1:0] head_b;

  disp_state_e        state_q, state_d;
  logic [A_width-1:0] a_q;
  logic [B_width-1:0] b_q;
  logic [1:0]         fun_q;
  unit_e              unit_q;
  logic [3:0]         en_q, en_d;
  logic               res_valid_q;
  logic [1:0]         res_sel_q;
  logic               run_q;

  // run_q keeps CMD_READY low while reset is asserted and until the first edge after it.
  assign CMD_READY = run_q && !fifo_full;
  assign push      = CMD_VALID && CMD_READY;

  alu_cmd_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK_CMP (CLK_CMP),
    .RST_CMP (RST_CMP),
    .push_i  (push),
    .wdata_i ({CMD_FUN, CMD_A, CMD_B}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_fun = head[FW-1 -: 4];
  assign head_a   = head[A_width+B_width-1 -: A_width];
  assign head_b   = head[B_width-1:0];

  // Next-state logic; a pop always coincides with entering ISSUE.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    en_d = pop ? unit_onehot(unit_e'(head_fun[3:2])) : 4'b0000;
  end

  // State, enables, result flag and held operands.
  // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
  always_ff @(posedge CLK_CMP or negedge RST_CMP) begin
    if (!RST_CMP) begin
      state_q     <= ST_IDLE;
      run_q       <= 1'b0;
      en_q        <= '0;
      res_valid_q <= 1'b0;
      res_sel_q   <= '0;
      a_q         <= '0;
      b_q         <= '0;
      fun_q       <= '0;
      unit_q      <= UNIT_ARITH;
    end else begin
      state_q     <= state_d;
      run_q       <= 1'b1;
      en_q        <= en_d;
      res_valid_q <= (state_q == ST_ISSUE);
      res_sel_q   <= (state_q == ST_ISSUE) ? unit_q : 2'b00;
      if (pop) begin
        a_q    <= head_a;
        b_q    <= head_b;
        fun_q  <= head_fun[1:0];
        unit_q <= unit_e'(head_fun[3:2]);
      end
    end
  end

  assign A_OUT       = a_q;
  assign B_OUT       = b_q;
  assign ALU_FUN_OUT = fun_q;
  assign ARITH_EN    = en_q[0];
  assign LOGIC_EN    = en_q[1];
  assign CMP_EN      = en_q[2];
  assign SHIFT_EN    = en_q[3];
  assign RES_VALID   = res_valid_q;
  assign RES_SEL     = res_sel_q;
  assign BUSY        = !fifo_empty || (state_q != ST_IDLE);

`ifdef ALU_DISP_STATS_EN
  logic [15:0] issue_cnt_q;

  // Count ISSUE cycles; wraps naturally at 16 bits.
  always_ff @(posedge CLK_CMP or negedge RST_CMP) begin
    if (!RST_CMP) issue_cnt_q <= '0;
    else if (state_q == ST_ISSUE) issue_cnt_q <= issue_cnt_q + 16'd1;
  end

  assign ISSUE_CNT = issue_cnt_q;
`else
  assign ISSUE_CNT = 16'h0000;
`endif

endmodule
